// File: rtl/fib_bcd_display_pkg.sv
// Shared types and 7-segment helpers for the Fibonacci result display path.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Segment patterns, a..g in bit 0..6, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fib_bcd_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per clock.
module bin2bcd_seq
    import fib_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  dropped_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_e             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   adj_c;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               done_q;
    logic               dropped_q;

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        adj_c = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shift_q   <= data_i;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(DATA_W);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= {adj_c[BCD_W-2:0], shift_q[DATA_W-1]};
                    shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                    if (start_i) begin
                        dropped_q <= 1'b1;
                    end
                end
                DONE: begin
                    bcd_q   <= scratch_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (start_i) begin
                        dropped_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd_o     = bcd_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign dropped_o = dropped_q;

endmodule

// File: rtl/fib_bcd_display.sv
// Captures the Fibonacci result, converts it to BCD and scans it onto a
// multiplexed 7-segment display.
module fib_bcd_display
    import fib_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [DATA_W-1:0]     result_in,
    input  logic                  result_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  conv_busy,
    output logic                  conv_done,
    output logic                  dropped,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] bcd_w;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   blank_c;
    logic [3:0]          nib_c;
    logic                zero_above;

    // A disabled design must not start new conversions.
    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (result_valid & ena),
        .data_i    (result_in),
        .bcd_o     (bcd_w),
        .busy_o    (conv_busy),
        .done_o    (conv_done),
        .dropped_o (dropped)
    );

    // Scan timing: the counter and digit index only advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (ena) begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Digit i>0 is leading when it and every higher nibble are zero.
    always_comb begin
        blank_c    = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_above = zero_above & (bcd_w[4*i +: 4] == 4'd0);
            blank_c[i] = zero_above & (BLANK_LZ != 0);
        end
    end

    always_comb begin
        nib_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_c = bcd_w[4*i +: 4];
            end
        end
        digit_sel_d = DIGITS'(1) << idx_d;
        if (!ena || blank_c[idx_d]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(nib_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            digit_sel_q <= DIGITS'(1);
            seg_q       <= SEG_0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign bcd_out   = bcd_w;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule
